ula_sequenciador: RTL
=====================

Name: ula_sequenciador

Overview:
- Control FSM for the ULA result path.
- Accepts one operation request at a time over a start/busy/done handshake and latches the operands.
- Drives the 3-bit select of the 8:1 result multiplexer.
- Launches and waits on the multi-cycle multiplier (op 4) and divider (op 7), then captures the selected result, width-masked per operation, into an output register with flags.

Parameters:
DATA_W, 4, operand width
RES_W, 8, result register width (widest mux input)
TIMEOUT, 16, max cycles waited for a multi-cycle unit's done before aborting

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request strobe, sampled only in IDLE
op  in  3  operation code, also the mux select value
a  in  DATA_W  operand A
b  in  DATA_W  operand B
res_in  in  RES_W  mux output; narrower mux inputs zero-extended by datapath
mul_done  in  1  multiplier completion pulse
div_done  in  1  divider completion pulse
op_a  out  DATA_W  latched operand A to datapath
op_b  out  DATA_W  latched operand B to datapath
sel  out  3  mux select
mul_start  out  1  one-cycle multiplier launch pulse
div_start  out  1  one-cycle divider launch pulse
result  out  RES_W  captured result
zero  out  1  result == 0 (valid with done)
err  out  1  divide-by-zero or timeout on the last operation
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0: op_a, op_b, sel, result, zero, err, busy, done, mul_start, div_start.
  - Wait counter 0.
- States: IDLE, EXEC, WAIT, CAPTURE, DONE. Encoding is free.
- IDLE:
  - busy=0.
  - On start=1: latch op into sel, a into op_a, b into op_b. Clear err. Go to EXEC.
  - busy=1 from the next cycle.
- start is ignored in every state other than IDLE. No queuing.
- sel, op_a and op_b hold stable from the latch cycle until the next accepted start.
- EXEC (1 cycle), by operation:
  - op=7 and op_b==0: no launch. result=8'hFF, err=1, zero=0. Go to DONE.
  - op=4: assert mul_start this cycle only. Clear counter. Go to WAIT.
  - op=7 (op_b != 0): assert div_start this cycle only. Clear counter. Go to WAIT.
  - Any other op: go to CAPTURE.
- WAIT:
  - Counter increments every cycle.
  - The done input of the launched unit (mul_done for op 4, div_done for op 7) goes to CAPTURE. The other unit's done is ignored.
  - A done arriving in the same cycle the counter reaches TIMEOUT-1: done wins, go to CAPTURE.
  - Counter reaches TIMEOUT-1 with no done: result=8'hFF, err=1, zero=0. Go to DONE.
- CAPTURE: register result = res_in AND mask(op).
  - ops 0,1,6: 5'b11111 mask, i.e. 8'h1F.
  - ops 2,3,5: 8'h01.
  - ops 4,7: 8'hFF.
  - zero = (masked value == 0).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy still 1. Go to IDLE.
- Latency, start sampled at edge N:
  - Single-cycle op: done high in cycle N+3.
  - Multi-cycle op whose unit done arrives k cycles after its start pulse (k ≥ 1): done high at N+3+k.
- result, zero and err hold until the next capture, abort, or reset.
- Late or unsolicited mul_done/div_done in IDLE, EXEC, CAPTURE or DONE: ignored, no state change.
- Reset asserted mid-WAIT: start pulses deassert immediately. A unit done arriving after release is ignored.

Test Plan:
1. Reset, then start with op=0, a=4'h9, b=4'h8, res_in=8'hF1 → sel=0 from N+1, done pulse at N+3, result=8'h11, zero=0, err=0, busy high N+1..N+3.
2. op=3 with res_in=8'hFE → result=8'h00, zero=1. Then start held high continuously → a new op accepted only on the cycle after done (IDLE), never while busy.
3. op=4, a=4'hF, b=4'hF; mul_done pulses 5 cycles after mul_start with res_in=8'hE1 → mul_start is exactly 1 cycle wide, div_start stays 0, result=8'hE1, done at N+8.
4. op=7, b=0 → no div_start, done at N+2, result=8'hFF, err=1. Next: op=7, b=3, div_done never arrives (TIMEOUT=16) → done after timeout, err=1, result=8'hFF. A spurious div_done afterwards in IDLE → no effect.
5. op=4 launched, rst asserted in the 2nd WAIT cycle → all outputs 0 asynchronously. mul_done pulsed after reset release → ignored, busy stays 0.
6. op=7, b=2, with div_done and the timeout boundary (counter=TIMEOUT-1) coinciding → normal capture, err=0. mul_done pulsed during WAIT → ignored.

Source files
------------

// File: rtl/ula_sequenciador.sv
// Control sequencer for the ULA result path: accepts one request at a time,
// drives the result mux select, launches the multi-cycle units and captures the masked result.
module ula_sequenciador #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [RES_W-1:0]  res_in,
  input  logic              mul_done,
  input  logic              div_done,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        sel,
  output logic              mul_start,
  output logic              div_start,
  output logic [RES_W-1:0]  result,
  output logic              zero,
  output logic              err,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, EXEC, WAIT, CAPTURE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            unit_done;
  logic [RES_W-1:0] masked;

  function automatic logic [RES_W-1:0] res_mask(input logic [2:0] o);
    logic [RES_W-1:0] m;
    m = '1;
    case (o)
      3'd0, 3'd1, 3'd6: m = RES_W'(5'h1F);
      3'd2, 3'd3, 3'd5: m = RES_W'(1'b1);
      default:          m = '1;
    endcase
    return m;
  endfunction

  always_comb begin
    unit_done = (sel == 3'd4) ? mul_done : div_done;
    masked    = res_in & res_mask(sel);
  end

  // Launch pulses are registered on acceptance so they are visible during the EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sel       <= '0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel       <= op;
            op_a      <= a;
            op_b      <= b;
            err       <= 1'b0;
            busy      <= 1'b1;
            mul_start <= (op == 3'd4);
            div_start <= (op == 3'd7) && (b != '0);
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (sel == 3'd7 && op_b == '0) begin
            result <= '1;
            err    <= 1'b1;
            zero   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (sel == 3'd4 || sel == 3'd7) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            state <= CAPTURE;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (unit_done) begin
            state <= CAPTURE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            result <= '1;
            err    <= 1'b1;
            zero   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        CAPTURE: begin
          result <= masked;
          zero   <= (masked == '0);
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
